// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one UART transmitter
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int DBITS        = 8,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DBITS-1:0]     req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_wr,
    output logic [DBITS-1:0]          tx_data,
    input  logic                      tx_busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      grant_active,
    output logic                      err_timeout
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [DBITS-1:0] tx_data_q, tx_data_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic             grant_active_q, grant_active_d;
    logic             last_q, last_d;

    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW:0]     cand;
    logic [DBITS-1:0] sel_data;
    logic             sel_last;
    logic             handshake;
    logic [IDW-1:0]   next_ptr;

    // Pick the requester to serve: the locked owner only, else first valid from rr_ptr upward
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        if (lock_q) begin
            sel_found = req_valid[grant_id_q];
            sel_idx   = grant_id_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                if (!sel_found && req_valid[cand[IDW-1:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand[IDW-1:0];
                end
            end
        end
    end

    // Route the selected requester's byte and last flag, and drive the one-hot ready
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == sel_idx) begin
                sel_data = req_data[k*DBITS +: DBITS];
                sel_last = req_last[k];
            end
        end
        if (state_q == IDLE && !tx_busy && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign handshake = |(req_ready & req_valid);
    assign next_ptr  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

    // Next-state and strobe logic for the issue / busy-rise / busy-fall sequence
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        lock_d         = lock_q;
        cnt_d          = cnt_q;
        tx_data_d      = tx_data_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        last_d         = last_q;
        tx_wr          = 1'b0;
        err_timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    tx_data_d      = sel_data;
                    last_d         = sel_last;
                    grant_id_d     = sel_idx;
                    grant_active_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                tx_wr   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    // Transmitter never acknowledged: drop the byte and free the channel
                    err_timeout    = 1'b1;
                    lock_d         = 1'b0;
                    rr_ptr_d       = next_ptr;
                    grant_active_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    if (last_q) begin
                        lock_d         = 1'b0;
                        rr_ptr_d       = next_ptr;
                        grant_active_d = 1'b0;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            cnt_q          <= '0;
            tx_data_q      <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_q         <= lock_d;
            cnt_q          <= cnt_d;
            tx_data_q      <= tx_data_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            last_q         <= last_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DBITS = 8;
    localparam int BT    = 64;

    logic                  PCLK;
    logic                  PRESETn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  tx_wr;
    logic [DBITS-1:0]      tx_data;
    logic                  tx_busy;
    logic [1:0]            grant_id;
    logic                  grant_active;
    logic                  err_timeout;

    uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .BUSY_TIMEOUT(BT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .grant_active(grant_active),
        .err_timeout(err_timeout)
    );

    typedef struct packed { logic [7:0] data; logic last; } item_t;
    typedef struct packed { logic is_err; logic [1:0] id; logic [7:0] data; } exp_t;

    item_t rq [NREQ][$];
    exp_t  exp_q [$];
    logic [NREQ-1:0] acc;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   wr_cyc = 0;
    int   err_cyc = 0;
    bit   err_seen = 0;
    bit   tx_dead = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        #3;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        rq[i].push_back(it);
    endtask

    task automatic expect_byte(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.id     = id;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] id);
        exp_t e;
        e.is_err = 1'b1;
        e.id     = id;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic wait_quiet(input string name, input int maxc);
        int q;
        int n;
        q = 0;
        n = 0;
        while (q < 6 && n < maxc) begin
            tick();
            n++;
            if (exp_q.size() == 0 && !tx_busy && !tx_wr) q++;
            else q = 0;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Transmitter model: busy rises two cycles after the write strobe, stays up eight
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge PCLK);
            if (tx_wr && !tx_dead) begin
                repeat (2) @(negedge PCLK);
                tx_busy = 1'b1;
                repeat (8) @(negedge PCLK);
                tx_busy = 1'b0;
            end
        end
    end

    // Requester models: present queue heads, retire them after an observed handshake
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        acc       = '0;
        forever begin
            @(negedge PCLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
                if (rq[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_data[i*DBITS +: 8]  = rq[i][0].data;
                    req_last[i]             = rq[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            #3;
            acc = req_valid & req_ready & {NREQ{PRESETn}};
        end
    end

    // Monitor: every write strobe or timeout pulse is matched against the expected queue
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            #2;
            if (PRESETn && tx_wr) begin
                wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_wr actual=id%0d/0x%0h expected=none", grant_id, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_tx", {21'd0, 1'b0, grant_id, tx_data}, {21'd0, e.is_err, e.id, e.data});
                end
            end
            if (PRESETn && err_timeout) begin
                err_cyc  = cyc;
                err_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_err actual=id%0d expected=none", grant_id);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_err", {21'd0, 1'b1, grant_id, 8'h00}, {21'd0, e.is_err, e.id, 8'h00});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        PRESETn = 1'b0;
        repeat (3) tick();
        check("rst_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_grant_active", 32'(grant_active), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        PRESETn = 1'b1;

        // Single byte from req0: latency and busy tracking
        push(0, 8'hA5, 1'b1);
        expect_byte(2'd0, 8'hA5);
        n = 0;
        while (!req_ready[0] && n < 20) begin tick(); n++; end
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        check("t1_tx_wr", 32'(tx_wr), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'hA5);
        check("t1_active", 32'(grant_active), 32'd1);
        tick();
        check("t1_wr_one_cycle", 32'(tx_wr), 32'd0);
        n = 0;
        while (!tx_busy && n < 20) begin tick(); n++; end
        check("t1_busy_rise", 32'(tx_busy), 32'd1);
        n = 0;
        while (tx_busy && n < 40) begin tick(); n++; end
        check("t1_busy_fall", 32'(tx_busy), 32'd0);
        check("t1_active_hold", 32'(grant_active), 32'd1);
        tick();
        check("t1_active_fall", 32'(grant_active), 32'd0);
        wait_quiet("t1", 100);

        // rr_ptr now 1: req1 beats req0
        push(0, 8'h01, 1'b1);
        push(1, 8'h02, 1'b1);
        expect_byte(2'd1, 8'h02);
        expect_byte(2'd0, 8'h01);
        wait_quiet("t1b", 200);

        // From reset, all four valid, then wrap back to req0
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            push(i, 8'h10 + 8'(i), 1'b1);
            expect_byte(2'(i), 8'h10 + 8'(i));
        end
        push(0, 8'h20, 1'b1);
        expect_byte(2'd0, 8'h20);
        wait_quiet("t2", 400);

        // req1 three-byte packet ahead of req2 and req3
        push(1, 8'hAA, 1'b0);
        push(1, 8'hAB, 1'b0);
        push(1, 8'hAC, 1'b1);
        push(2, 8'h5C, 1'b1);
        push(3, 8'h3D, 1'b1);
        expect_byte(2'd1, 8'hAA);
        expect_byte(2'd1, 8'hAB);
        expect_byte(2'd1, 8'hAC);
        expect_byte(2'd2, 8'h5C);
        expect_byte(2'd3, 8'h3D);
        wait_quiet("t3", 400);

        // Lock held while req1 idles mid-packet with req0 waiting
        push(1, 8'h71, 1'b0);
        expect_byte(2'd1, 8'h71);
        wait_quiet("t4a", 200);
        push(0, 8'h0F, 1'b1);
        repeat (500) tick();
        check("t4_lock_active", 32'(grant_active), 32'd1);
        check("t4_lock_id", 32'(grant_id), 32'd1);
        check("t4_req0_blocked", 32'(req_ready), 32'd0);
        push(1, 8'h72, 1'b0);
        push(1, 8'h73, 1'b1);
        expect_byte(2'd1, 8'h72);
        expect_byte(2'd1, 8'h73);
        expect_byte(2'd0, 8'h0F);
        wait_quiet("t4b", 400);

        // Busy never rises: timeout, lock cleared, req2 served before req1's next byte
        tx_dead = 1'b1;
        push(1, 8'h99, 1'b0);
        push(1, 8'h9A, 1'b1);
        push(2, 8'h22, 1'b1);
        expect_byte(2'd1, 8'h99);
        expect_err(2'd1);
        expect_byte(2'd2, 8'h22);
        expect_byte(2'd1, 8'h9A);
        n = 0;
        while (!err_seen && n < 200) begin tick(); n++; end
        check("t5_err_seen", 32'(err_seen), 32'd1);
        check("t5_err_delay", 32'(err_cyc - wr_cyc), 32'(BT));
        tx_dead = 1'b0;
        tick();
        check("t5_err_pulse", 32'(err_timeout), 32'd0);
        check("t5_idle", 32'(grant_active), 32'd0);
        check("t5_next_ready", 32'(req_ready), 32'h4);
        wait_quiet("t5", 400);

        // Reset during WAIT_DONE of a locked packet
        push(3, 8'hC1, 1'b0);
        push(3, 8'hC2, 1'b0);
        expect_byte(2'd3, 8'hC1);
        expect_byte(2'd3, 8'hC2);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
        n = 0;
        while (!tx_busy && n < 20) begin tick(); n++; end
        check("t6_in_wait_done", 32'(tx_busy), 32'd1);
        push(0, 8'h05, 1'b1);
        push(2, 8'h25, 1'b1);
        expect_byte(2'd0, 8'h05);
        expect_byte(2'd2, 8'h25);
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        check("t6_rst_tx_data", 32'(tx_data), 32'd0);
        check("t6_rst_grant_id", 32'(grant_id), 32'd0);
        check("t6_rst_active", 32'(grant_active), 32'd0);
        check("t6_rst_tx_wr", 32'(tx_wr), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        wait_quiet("t6", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
